// File: rtl/i2s_rx_if.sv
// I2S receive-side bundle: serial pins from the source and the parallel
// sample outputs presented by the receiver.
interface i2s_rx_if #(
  parameter int unsigned WIDTH = 16
);
  logic             sclk;
  logic             lrclk;
  logic             sdin;
  logic [WIDTH-1:0] sample_l;
  logic [WIDTH-1:0] sample_r;
  logic             sample_valid;
  logic             frame_err;

  modport master (
    output sclk, lrclk, sdin,
    input  sample_l, sample_r, sample_valid, frame_err
  );

  modport slave (
    input  sclk, lrclk, sdin,
    output sample_l, sample_r, sample_valid, frame_err
  );
endinterface

// File: rtl/i2s_rx.sv
// Stereo I2S receiver: oversamples sclk/lrclk/sdin in the clk domain, locks to
// word-select transitions and emits each left/right pair with a valid strobe.
module i2s_rx #(
  parameter int unsigned WIDTH = 16
) (
  input logic   clk,
  input logic   rst_n,
  i2s_rx_if.slave bus
);

  localparam int unsigned     CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,  // waiting for the first sclk edge to sample lrclk
    ST_SYNC,  // lr_prev loaded, waiting for an lrclk transition
    ST_RUN    // locked to slot boundaries
  } state_t;

  logic [1:0]       sclk_sync;
  logic [1:0]       lr_sync;
  logic [1:0]       sd_sync;
  logic             sclk_prev;
  logic             edge_q;
  logic             lr_q;
  logic             sd_q;

  state_t           state;
  logic             lr_prev;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_l;
  logic             left_ok;
  logic [WIDTH-1:0] sample_l_q;
  logic [WIDTH-1:0] sample_r_q;
  logic             sample_valid_q;
  logic             frame_err_q;

  logic             room;
  logic [WIDTH-1:0] word_next;
  logic [CW-1:0]    cnt_next;

  // Edge detect is registered together with the same-stage lrclk/sdin so the
  // slot logic sees a coherent snapshot one cycle after detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      sclk_prev <= 1'b0;
      edge_q    <= 1'b0;
      lr_q      <= 1'b0;
      sd_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.sclk};
      lr_sync   <= {lr_sync[0], bus.lrclk};
      sd_sync   <= {sd_sync[0], bus.sdin};
      sclk_prev <= sclk_sync[1];
      edge_q    <= sclk_sync[1] & ~sclk_prev;
      lr_q      <= lr_sync[1];
      sd_q      <= sd_sync[1];
    end
  end

  always_comb begin
    room      = (bitcnt < FULL);
    word_next = shreg;
    cnt_next  = bitcnt;
    if (room) begin
      word_next = {shreg[WIDTH-2:0], sd_q};
      cnt_next  = bitcnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      lr_prev        <= 1'b0;
      bitcnt         <= '0;
      shreg          <= '0;
      hold_l         <= '0;
      left_ok        <= 1'b0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      if (edge_q) begin
        case (state)
          ST_IDLE: begin
            lr_prev <= lr_q;
            state   <= ST_SYNC;
          end
          ST_SYNC: begin
            if (lr_q != lr_prev) begin
              state   <= ST_RUN;
              bitcnt  <= '0;
              left_ok <= 1'b0;
              lr_prev <= lr_q;
            end
          end
          ST_RUN: begin
            if (lr_q == lr_prev) begin
              shreg  <= word_next;
              bitcnt <= cnt_next;
            end else begin
              // One-bit I2S delay: this edge carries the LSB of the ending slot.
              if (cnt_next == FULL) begin
                if (!lr_prev) begin
                  hold_l  <= word_next;
                  left_ok <= 1'b1;
                end else if (left_ok) begin
                  sample_l_q     <= hold_l;
                  sample_r_q     <= word_next;
                  sample_valid_q <= 1'b1;
                  left_ok        <= 1'b0;
                end
              end else begin
                frame_err_q <= 1'b1;
                left_ok     <= 1'b0;
              end
              bitcnt  <= '0;
              lr_prev <= lr_q;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sample_l     = sample_l_q;
  assign bus.sample_r     = sample_r_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames at clk = 8 x sclk and checks
// sample pairs, error pulses, latency and reset behaviour.
module tb_i2s_rx;

  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;

  i2s_rx_if #(.WIDTH(W)) bus ();

  i2s_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  int cycle;
  int valid_cnt;
  int err_cnt;
  int valid_cyc;
  int last_rise;
  int lsb_rise;
  int rst_viol;
  int hold_viol;
  int long_cnt;
  int both_cnt;
  logic [W-1:0] first_l;
  logic [W-1:0] first_r;
  logic [W-1:0] prev_l;
  logic [W-1:0] prev_r;
  logic         prev_valid;
  logic         prev_err;
  logic         prev_rst_n;
  logic         pend;

  // Cycle-level observer, sampling 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    cycle = cycle + 1;
    if (bus.sample_valid) begin
      if (valid_cnt == 0) begin
        first_l = bus.sample_l;
        first_r = bus.sample_r;
      end
      valid_cnt = valid_cnt + 1;
      valid_cyc = cycle;
    end
    if (bus.frame_err) err_cnt = err_cnt + 1;
    if (bus.sample_valid && bus.frame_err) both_cnt = both_cnt + 1;
    if ((bus.sample_valid && prev_valid) || (bus.frame_err && prev_err)) long_cnt = long_cnt + 1;
    if (!rst_n && (bus.sample_l != '0 || bus.sample_r != '0 || bus.sample_valid || bus.frame_err))
      rst_viol = rst_viol + 1;
    if (rst_n && prev_rst_n && !bus.sample_valid &&
        (bus.sample_l != prev_l || bus.sample_r != prev_r))
      hold_viol = hold_viol + 1;
    prev_l     = bus.sample_l;
    prev_r     = bus.sample_r;
    prev_valid = bus.sample_valid;
    prev_err   = bus.frame_err;
    prev_rst_n = rst_n;
  end

  task automatic clear_counts();
    valid_cnt = 0;
    err_cnt   = 0;
    first_l   = '0;
    first_r   = '0;
  endtask

  // One sclk period: data changes with the falling edge, the bit queued by
  // the previous call goes out now (I2S one-bit delay).
  task automatic send_period(input logic lr, input logic b);
    bus.sclk  = 1'b0;
    bus.lrclk = lr;
    bus.sdin  = pend;
    pend      = b;
    repeat (4) @(negedge clk);
    bus.sclk  = 1'b1;
    last_rise = cycle;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] word, input int nbits, input int len);
    logic b;
    for (int i = 0; i < len; i++) begin
      b = (i < nbits) ? word[nbits-1-i] : 1'b0;
      send_period(lr, b);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int nl, input int nr, input int len_l, input int len_r);
    send_slot(1'b0, l, nl, len_l);
    send_slot(1'b1, r, nr, len_r);
  endtask

  task automatic preamble();
    pend = 1'b0;
    send_period(1'b1, 1'b0);
    send_period(1'b1, 1'b0);
  endtask

  task automatic flush();
    send_period(1'b0, 1'b0);
    lsb_rise = last_rise;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (6) @(negedge clk);
    checks++; if (bus.sample_l !== 16'h0000) begin failures++; $display("FAIL reset_l: got %h expected 0000", bus.sample_l); end
    checks++; if (bus.sample_r !== 16'h0000) begin failures++; $display("FAIL reset_r: got %h expected 0000", bus.sample_r); end
    checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.frame_err); end
    clear_counts();
    preamble();
    send_frame(32'h1234, 32'hABCD, 16, 16, 16, 16);
    send_frame(32'h1234, 32'hABCD, 16, 16, 16, 16);
    flush();
    checks++; if (valid_cnt !== 0) begin failures++; $display("FAIL reset_hold_valid: got %0d pulses expected 0", valid_cnt); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL reset_hold_err: got %0d pulses expected 0", err_cnt); end
    checks++; if (rst_viol !== 0) begin failures++; $display("FAIL reset_outputs: got %0d nonzero cycles expected 0", rst_viol); end
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_counts();
    preamble();
    send_frame(32'h1234, 32'hABCD, 16, 16, 16, 16);
    flush();
    checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL after_reset_valid: got %0d pulses expected 1", valid_cnt); end
    checks++; if (bus.sample_l !== 16'h1234) begin failures++; $display("FAIL after_reset_l: got %h expected 1234", bus.sample_l); end
  endtask

  task automatic test_basic();
    do_reset(3);
    clear_counts();
    preamble();
    for (int f = 0; f < 3; f++) send_frame(32'h1234, 32'hABCD, 16, 16, 16, 16);
    flush();
    checks++; if (valid_cnt !== 3) begin failures++; $display("FAIL basic_count: got %0d pulses expected 3", valid_cnt); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL basic_err: got %0d pulses expected 0", err_cnt); end
    checks++; if (bus.sample_l !== 16'h1234) begin failures++; $display("FAIL basic_l: got %h expected 1234", bus.sample_l); end
    checks++; if (bus.sample_r !== 16'hABCD) begin failures++; $display("FAIL basic_r: got %h expected abcd", bus.sample_r); end
    checks++; if (valid_cyc - lsb_rise !== 4) begin failures++; $display("FAIL basic_latency: got %0d clk expected 4", valid_cyc - lsb_rise); end
  endtask

  task automatic test_long_slots();
    do_reset(3);
    clear_counts();
    preamble();
    send_frame(32'h8001FFFF, 32'h7FFE0000, 32, 32, 32, 32);
    send_frame(32'h8001FFFF, 32'h7FFE0000, 32, 32, 32, 32);
    flush();
    checks++; if (valid_cnt !== 2) begin failures++; $display("FAIL long_count: got %0d pulses expected 2", valid_cnt); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL long_err: got %0d pulses expected 0", err_cnt); end
    checks++; if (bus.sample_l !== 16'h8001) begin failures++; $display("FAIL long_l: got %h expected 8001", bus.sample_l); end
    checks++; if (bus.sample_r !== 16'h7FFE) begin failures++; $display("FAIL long_r: got %h expected 7ffe", bus.sample_r); end
  endtask

  task automatic test_short_slot();
    do_reset(3);
    clear_counts();
    preamble();
    send_frame(32'h0001, 32'h0002, 16, 16, 16, 16);
    send_frame(32'h00A5, 32'h5555, 8, 16, 8, 16);
    send_frame(32'h1234, 32'h5555, 16, 16, 16, 16);
    flush();
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL short_err: got %0d pulses expected 1", err_cnt); end
    checks++; if (valid_cnt !== 2) begin failures++; $display("FAIL short_valid: got %0d pulses expected 2", valid_cnt); end
    checks++; if (first_l !== 16'h0001) begin failures++; $display("FAIL short_first_l: got %h expected 0001", first_l); end
    checks++; if (bus.sample_l !== 16'h1234) begin failures++; $display("FAIL short_l: got %h expected 1234", bus.sample_l); end
    checks++; if (bus.sample_r !== 16'h5555) begin failures++; $display("FAIL short_r: got %h expected 5555", bus.sample_r); end
  endtask

  task automatic test_zero_bit_toggle();
    do_reset(3);
    clear_counts();
    preamble();
    send_frame(32'h1357, 32'h2468, 16, 16, 16, 16);
    send_period(1'b0, 1'b0);
    send_period(1'b1, 1'b0);
    send_period(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL toggle_valid: got %0d pulses expected 1", valid_cnt); end
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL toggle_err: got %0d pulses expected 1", err_cnt); end
    checks++; if (bus.sample_r !== 16'h2468) begin failures++; $display("FAIL toggle_r: got %h expected 2468", bus.sample_r); end
  endtask

  task automatic test_mid_frame_start();
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    clear_counts();
    fork
      begin
        preamble();
        send_frame(32'h1111, 32'h2222, 16, 16, 16, 16);
        send_frame(32'h3C3C, 32'h5A5A, 16, 16, 16, 16);
        flush();
      end
      begin
        repeat (208) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL mid_err: got %0d pulses expected 0", err_cnt); end
    checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL mid_valid: got %0d pulses expected 1", valid_cnt); end
    checks++; if (bus.sample_l !== 16'h3C3C) begin failures++; $display("FAIL mid_l: got %h expected 3c3c", bus.sample_l); end
    checks++; if (bus.sample_r !== 16'h5A5A) begin failures++; $display("FAIL mid_r: got %h expected 5a5a", bus.sample_r); end
  endtask

  task automatic test_reset_mid_word();
    do_reset(3);
    clear_counts();
    preamble();
    send_frame(32'h1111, 32'h2222, 16, 16, 16, 16);
    fork
      begin
        send_frame(32'hAAAA, 32'hBBBB, 16, 16, 16, 16);
        send_frame(32'h0F0F, 32'hF0F0, 16, 16, 16, 16);
        send_frame(32'h0F0F, 32'hF0F0, 16, 16, 16, 16);
        flush();
      end
      begin
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.sample_l !== 16'h0000) begin failures++; $display("FAIL midrst_l: got %h expected 0000", bus.sample_l); end
        checks++; if (bus.sample_r !== 16'h0000) begin failures++; $display("FAIL midrst_r: got %h expected 0000", bus.sample_r); end
        rst_n = 1'b1;
        clear_counts();
      end
    join
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL midrst_err: got %0d pulses expected 0", err_cnt); end
    checks++; if (valid_cnt !== 2) begin failures++; $display("FAIL midrst_valid: got %0d pulses expected 2", valid_cnt); end
    checks++; if (first_l !== 16'h0F0F) begin failures++; $display("FAIL midrst_first_l: got %h expected 0f0f", first_l); end
    checks++; if (first_r !== 16'hF0F0) begin failures++; $display("FAIL midrst_first_r: got %h expected f0f0", first_r); end
  endtask

  task automatic test_pulse_rules();
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin failures++; $display("FAIL pulse_width: got %0d stretched pulses expected 0", long_cnt); end
    checks++; if (hold_viol !== 0) begin failures++; $display("FAIL sample_hold: got %0d changes without valid expected 0", hold_viol); end
    checks++; if (rst_viol !== 0) begin failures++; $display("FAIL reset_outputs_all: got %0d nonzero cycles expected 0", rst_viol); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cycle      = 0;
    valid_cnt  = 0;
    err_cnt    = 0;
    valid_cyc  = 0;
    last_rise  = 0;
    lsb_rise   = 0;
    rst_viol   = 0;
    hold_viol  = 0;
    long_cnt   = 0;
    both_cnt   = 0;
    first_l    = '0;
    first_r    = '0;
    prev_l     = '0;
    prev_r     = '0;
    prev_valid = 1'b0;
    prev_err   = 1'b0;
    prev_rst_n = 1'b0;
    pend       = 1'b0;
    rst_n      = 1'b0;
    bus.sclk   = 1'b0;
    bus.lrclk  = 1'b0;
    bus.sdin   = 1'b0;

    test_reset();
    test_basic();
    test_long_slots();
    test_short_slot();
    test_zero_bit_toggle();
    test_mid_frame_start();
    test_reset_mid_word();
    test_pulse_rules();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
